// File: rtl/seg7_pkg.sv
// Shared 7-segment glyph constants and reader FSM state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seg7_pkg;

  // Segment patterns, bit0=a .. bit6=g, active-high.
  // The display encoder uses the same constants, so both directions stay consistent.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_decode.sv
// Maps a 7-segment pattern to {legal hex glyph, blank, digit}.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       legal,
  output logic       is_blank,
  output logic [3:0] digit
);

  // Glyph lookup; anything not in the table is neither legal nor blank.
  always_comb begin
    legal    = 1'b1;
    is_blank = 1'b0;
    digit    = 4'h0;
    case (pattern)
      SEG_0:     digit = 4'h0;
      SEG_1:     digit = 4'h1;
      SEG_2:     digit = 4'h2;
      SEG_3:     digit = 4'h3;
      SEG_4:     digit = 4'h4;
      SEG_5:     digit = 4'h5;
      SEG_6:     digit = 4'h6;
      SEG_7:     digit = 4'h7;
      SEG_8:     digit = 4'h8;
      SEG_9:     digit = 4'h9;
      SEG_A:     digit = 4'hA;
      SEG_B:     digit = 4'hB;
      SEG_C:     digit = 4'hC;
      SEG_D:     digit = 4'hD;
      SEG_E:     digit = 4'hE;
      SEG_F:     digit = 4'hF;
      SEG_BLANK: begin
        legal    = 1'b0;
        is_blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// Recovers hex digits from an asynchronous 7-segment bus: sync, debounce, decode, sequence check.
// Latency: events registered STABLE_CYCLES+2 edges after the first sampling edge of a new pattern.
// Backpressure: none; event outputs are single-cycle pulses and are not held.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit_out,
  output logic             digit_valid,
  output logic             blank,
  output logic             pattern_err,
  output logic             seq_err,
  output logic [CNT_W-1:0] seq_ok_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [7:0]       STABLE_W = 8'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [6:0]       s1_q, s1_d, s2_q, s2_d;
  logic [6:0]       cand_q, cand_d, last_q, last_d;
  logic [7:0]       stab_q, stab_d;
  state_e           state_q, state_d;
  logic             have_prev_q, have_prev_d;
  logic [3:0]       digit_q, digit_d;
  logic             dv_q, dv_d, blank_q, blank_d;
  logic             perr_q, perr_d, serr_q, serr_d;
  logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d, err_cnt_q, err_cnt_d;

  logic             evaluate;
  logic             dec_legal, dec_blank;
  logic [3:0]       dec_digit;

  // The candidate is the only pattern ever evaluated, so decode it directly.
  seg7_decode u_decode (
    .pattern  (cand_q),
    .legal    (dec_legal),
    .is_blank (dec_blank),
    .digit    (dec_digit)
  );

  // Next-state logic: synchroniser shift, debounce FSM, evaluation and counters.
  always_comb begin
    s1_d        = seg_in;
    s2_d        = s1_q;
    state_d     = state_q;
    cand_d      = cand_q;
    stab_d      = stab_q;
    last_d      = last_q;
    have_prev_d = have_prev_q;
    digit_d     = digit_q;
    blank_d     = blank_q;
    dv_d        = 1'b0;
    perr_d      = 1'b0;
    serr_d      = 1'b0;
    ok_cnt_d    = ok_cnt_q;
    err_cnt_d   = err_cnt_q;
    evaluate    = 1'b0;

    case (state_q)
      IDLE: begin
        if (s2_q != cand_q) begin
          cand_d  = s2_q;
          stab_d  = 8'd1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (s2_q != cand_q) begin
          cand_d = s2_q;
          stab_d = 8'd1;
        end else if (stab_q == STABLE_W) begin
          evaluate = 1'b1;
          state_d  = LOCKED;
        end else begin
          stab_d = stab_q + 8'd1;
        end
      end
      LOCKED: begin
        if (s2_q != cand_q) begin
          cand_d  = s2_q;
          stab_d  = 8'd1;
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Re-settling onto the already accepted pattern (a glitch) emits nothing.
    if (evaluate && (cand_q != last_q)) begin
      last_d = cand_q;
      if (dec_legal) begin
        digit_d = dec_digit;
        dv_d    = 1'b1;
        blank_d = 1'b0;
        if (have_prev_q) begin
          if (dec_digit == digit_q + 4'd1) begin
            if (ok_cnt_q != CNT_MAX) ok_cnt_d = ok_cnt_q + CNT_W'(1);
          end else begin
            serr_d = 1'b1;
            if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_W'(1);
          end
        end
        have_prev_d = 1'b1;
      end else if (dec_blank) begin
        blank_d = 1'b1;
      end else begin
        perr_d = 1'b1;
        if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      state_q     <= IDLE;
      cand_q      <= '0;
      stab_q      <= '0;
      last_q      <= '0;
      have_prev_q <= 1'b0;
      digit_q     <= '0;
      blank_q     <= 1'b0;
      dv_q        <= 1'b0;
      perr_q      <= 1'b0;
      serr_q      <= 1'b0;
      ok_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      stab_q      <= stab_d;
      last_q      <= last_d;
      have_prev_q <= have_prev_d;
      digit_q     <= digit_d;
      blank_q     <= blank_d;
      dv_q        <= dv_d;
      perr_q      <= perr_d;
      serr_q      <= serr_d;
      ok_cnt_q    <= ok_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign digit_out    = digit_q;
  assign digit_valid  = dv_q;
  assign blank        = blank_q;
  assign pattern_err  = perr_q;
  assign seq_err      = serr_q;
  assign seq_ok_count = ok_cnt_q;
  assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Scoreboard bench for seg7_reader: directed glyph steps push expected events, a monitor pops them.
// Latency: expects each event exactly 7 negedges after the stimulus negedge (STABLE_CYCLES=4).
// Backpressure: n/a.
module tb_seg7_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_in;
  logic [3:0] digit_out;
  logic       digit_valid, blank, pattern_err, seq_err;
  logic [7:0] seq_ok_count, err_count;

  always #5 clk = ~clk;

  seg7_reader #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_in       (seg_in),
    .digit_out    (digit_out),
    .digit_valid  (digit_valid),
    .blank        (blank),
    .pattern_err  (pattern_err),
    .seq_err      (seq_err),
    .seq_ok_count (seq_ok_count),
    .err_count    (err_count)
  );

  typedef struct {
    int         cyc;
    logic       pe;
    logic       se;
    logic [3:0] digit;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always @(posedge clk) cyc <= cyc + 1;

  // kind: 1 = digit in sequence/first, 2 = digit with seq_err, 3 = pattern_err
  task automatic push(input int kind, input logic [3:0] dg);
    exp_t x;
    x.cyc   = cyc + 7;
    x.pe    = (kind == 3);
    x.se    = (kind == 2);
    x.digit = dg;
    q.push_back(x);
  endtask

  task automatic step(input logic [6:0] pat, input int n, input int kind, input logic [3:0] dg);
    seg_in = pat;
    if (kind != 0) push(kind, dg);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_digit_out"}, int'(digit_out), 0);
    chk({tag, "_digit_valid"}, int'(digit_valid), 0);
    chk({tag, "_blank"}, int'(blank), 0);
    chk({tag, "_pattern_err"}, int'(pattern_err), 0);
    chk({tag, "_seq_err"}, int'(seq_err), 0);
    chk({tag, "_seq_ok_count"}, int'(seq_ok_count), 0);
    chk({tag, "_err_count"}, int'(err_count), 0);
  endtask

  // Monitor: every event pulse must match the head of the queue, in the expected cycle.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (digit_valid || pattern_err || seq_err) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event cyc=%0d dv=%b pe=%b se=%b digit=%h",
                   cyc, digit_valid, pattern_err, seq_err, digit_out);
        end else begin
          e = q.pop_front();
          if (cyc != e.cyc || digit_valid != !e.pe || pattern_err != e.pe ||
              seq_err != e.se || (!e.pe && digit_out != e.digit)) begin
            failures++;
            $display("FAIL event actual cyc=%0d dv=%b pe=%b se=%b digit=%h expected cyc=%0d dv=%b pe=%b se=%b digit=%h",
                     cyc, digit_valid, pattern_err, seq_err, digit_out,
                     e.cyc, !e.pe, e.pe, e.se, e.digit);
          end
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_event actual=none expected_cyc=%0d digit=%h", q[0].cyc, q[0].digit);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    seg_in = 7'h00;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // First digit: no previous, so no sequence verdict.
    step(7'h3F, 10, 1, 4'h0);
    chk("first_seq_ok", int'(seq_ok_count), 0);
    chk("first_err", int'(err_count), 0);
    chk("first_digit", int'(digit_out), 0);

    // Full 1..F then wrap to 0: all in sequence.
    for (int i = 1; i < 16; i++) step(glyphs[i], 10, 1, 4'(i));
    step(7'h3F, 10, 1, 4'h0);
    chk("walk_seq_ok", int'(seq_ok_count), 16);
    chk("walk_err", int'(err_count), 0);
    chk("walk_digit", int'(digit_out), 0);

    // Short glitch to 8 then back to 0: nothing emitted.
    step(7'h7F, 2, 0, 4'h0);
    step(7'h3F, 10, 0, 4'h0);
    chk("glitch_seq_ok", int'(seq_ok_count), 16);
    chk("glitch_err", int'(err_count), 0);

    // Illegal pattern, then 0 again (0 after 0 breaks the sequence).
    step(7'h55, 10, 3, 4'h0);
    chk("illegal_err", int'(err_count), 1);
    chk("illegal_digit", int'(digit_out), 0);
    chk("illegal_blank", int'(blank), 0);
    step(7'h3F, 10, 2, 4'h0);
    chk("reaccept_err", int'(err_count), 2);

    // Blank then 3: blank level, digit held, then 0 -> 3 is a sequence error.
    step(7'h00, 10, 0, 4'h0);
    chk("blank_level", int'(blank), 1);
    chk("blank_digit_held", int'(digit_out), 0);
    step(7'h4F, 10, 2, 4'h3);
    chk("after_blank_level", int'(blank), 0);
    chk("after_blank_digit", int'(digit_out), 3);
    chk("after_blank_err", int'(err_count), 3);
    chk("after_blank_seq_ok", int'(seq_ok_count), 16);

    // Reset during SETTLE of 1; the re-settled 1 is a fresh first digit.
    seg_in = 7'h06;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    rst_n = 1'b1;
    push(1, 4'h1);
    repeat (10) @(negedge clk);
    chk("postrst_digit", int'(digit_out), 1);
    chk("postrst_seq_ok", int'(seq_ok_count), 0);
    chk("postrst_err", int'(err_count), 0);

    // 300 sequence errors alternating 0 and 2: err_count saturates.
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) step(7'h3F, 8, 2, 4'h0);
      else            step(7'h5B, 8, 2, 4'h2);
    end
    chk("sat_err", int'(err_count), 255);
    chk("sat_seq_ok", int'(seq_ok_count), 0);

    repeat (10) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
